// File: rtl/mips_tb_pkg.sv
// Shared definitions for the memory sort checker: scan FSM encoding and the
// ordering predicate used to judge adjacent word pairs.
package mips_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  // Operands arrive already sign- or zero-extended to this width.
  localparam int MAX_W = 64;

  function automatic logic is_out_of_order(
    input logic [MAX_W-1:0] prev_word,
    input logic [MAX_W-1:0] cur_word,
    input logic             is_signed,
    input logic             descend
  );
    logic lt;
    logic gt;
    if (is_signed) begin
      lt = $signed(prev_word) < $signed(cur_word);
      gt = $signed(prev_word) > $signed(cur_word);
    end else begin
      lt = prev_word < cur_word;
      gt = prev_word > cur_word;
    end
    return descend ? lt : gt;
  endfunction

endpackage

// File: rtl/order_cmp.sv
// Flags an adjacent pair (previous word, current word) that violates the
// configured ordering (signed/unsigned, ascending/descending).
module order_cmp
  import mips_tb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter bit SIGNED  = 1'b0,
  parameter bit DESCEND = 1'b1
) (
  input  logic [DATA_W-1:0] prev_word,
  input  logic [DATA_W-1:0] cur_word,
  output logic              out_of_order
);

  logic [MAX_W-1:0] prev_x;
  logic [MAX_W-1:0] cur_x;

  generate
    if (SIGNED) begin : g_sext
      assign prev_x = MAX_W'($signed(prev_word));
      assign cur_x  = MAX_W'($signed(cur_word));
    end else begin : g_zext
      assign prev_x = MAX_W'(prev_word);
      assign cur_x  = MAX_W'(cur_word);
    end
  endgenerate

  assign out_of_order = is_out_of_order(prev_x, cur_x, SIGNED, DESCEND);

endmodule

// File: rtl/mem_sort_checker.sv
// Scans N consecutive memory words after a start pulse, counting out-of-order
// adjacent pairs and mismatches against an expected-value store.
module mem_sort_checker
  import mips_tb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int N         = 96,
  parameter int BASE_WORD = 32,
  parameter int ADDR_W    = 10,
  parameter int SIGNED    = 0,
  parameter int DESCEND   = 1,
  parameter int TIMEOUT   = 25840
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [ADDR_W-1:0]         exp_addr,
  input  logic [DATA_W-1:0]         exp_data,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(N+1)-1:0]    err_unsorted,
  output logic [$clog2(N+1)-1:0]    err_exp,
  output logic                      pass,
  output logic                      timeout
);

  localparam int CW = $clog2(N+1);
  localparam int IW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT+2);

  scan_state_e       state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [CW-1:0]     err_uns_q, err_uns_d;
  logic [CW-1:0]     err_exp_q, err_exp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [TW-1:0]     cyc_q, cyc_d;
  logic              started_q, started_d;
  logic              timeout_q, timeout_d;
  logic              pair_bad;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= CW'(N)) ? v : v + 1'b1;
  endfunction

  order_cmp #(
    .DATA_W  (DATA_W),
    .SIGNED  (SIGNED != 0),
    .DESCEND (DESCEND != 0)
  ) u_order_cmp (
    .prev_word    (prev_q),
    .cur_word     (mem_rdata),
    .out_of_order (pair_bad)
  );

  // Scan FSM: start is only honoured outside SCAN.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    prev_d    = prev_q;
    err_uns_d = err_uns_q;
    err_exp_d = err_exp_q;
    busy_d    = busy_q;
    done_d    = done_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_SCAN;
          idx_d     = '0;
          err_uns_d = '0;
          err_exp_d = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
        end
      end
      ST_SCAN: begin
        prev_d = mem_rdata;
        if (mem_rdata != exp_data) err_exp_d = sat_inc(err_exp_q);
        if ((idx_q != '0) && pair_bad) err_uns_d = sat_inc(err_uns_q);
        if (idx_q == IW'(N-1)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // Watchdog from reset release to the first start; timeout is sticky.
  always_comb begin
    cyc_d     = cyc_q;
    started_d = started_q;
    timeout_d = timeout_q;
    if (!started_q) begin
      if (cyc_q > TW'(TIMEOUT)) timeout_d = 1'b1;
      if (cyc_q != TW'(TIMEOUT+1)) cyc_d = cyc_q + 1'b1;
      if (start) started_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      prev_q    <= '0;
      err_uns_q <= '0;
      err_exp_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cyc_q     <= '0;
      started_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      prev_q    <= prev_d;
      err_uns_q <= err_uns_d;
      err_exp_q <= err_exp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cyc_q     <= cyc_d;
      started_q <= started_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    mem_addr = '0;
    exp_addr = '0;
    if (state_q == ST_SCAN) begin
      mem_addr = ADDR_W'(BASE_WORD) + ADDR_W'(idx_q);
      exp_addr = ADDR_W'(idx_q);
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign err_unsorted = err_uns_q;
  assign err_exp      = err_exp_q;
  assign timeout      = timeout_q;
  assign pass         = done_q & (err_uns_q == '0) & (err_exp_q == '0);

endmodule

// File: tb/tb_mem_sort_checker.sv
// Bench for mem_sort_checker: three N=4 instances (unsigned descending,
// signed descending, unsigned ascending with a short watchdog).
module tb_mem_sort_checker;

  localparam int NW = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start_v [3];
  logic [AW-1:0] maddr_v [3];
  logic [AW-1:0] eaddr_v [3];
  logic [DW-1:0] rdata_v [3];
  logic [DW-1:0] edata_v [3];
  logic          busy_v  [3];
  logic          done_v  [3];
  logic          pass_v  [3];
  logic          tmo_v   [3];
  logic [CW-1:0] eu_v    [3];
  logic [CW-1:0] ee_v    [3];

  logic [DW-1:0] mem_m [3][1024];
  logic [DW-1:0] exp_m [3][1024];

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;

  assign rdata_v[0] = mem_m[0][maddr_v[0]];
  assign rdata_v[1] = mem_m[1][maddr_v[1]];
  assign rdata_v[2] = mem_m[2][maddr_v[2]];
  assign edata_v[0] = exp_m[0][eaddr_v[0]];
  assign edata_v[1] = exp_m[1][eaddr_v[1]];
  assign edata_v[2] = exp_m[2][eaddr_v[2]];

  mem_sort_checker #(.DATA_W(32), .N(4), .BASE_WORD(32), .ADDR_W(10),
                     .SIGNED(0), .DESCEND(1), .TIMEOUT(25840)) u_u (
    .clk(clk), .reset(reset), .start(start_v[0]),
    .mem_addr(maddr_v[0]), .mem_rdata(rdata_v[0]),
    .exp_addr(eaddr_v[0]), .exp_data(edata_v[0]),
    .busy(busy_v[0]), .done(done_v[0]),
    .err_unsorted(eu_v[0]), .err_exp(ee_v[0]),
    .pass(pass_v[0]), .timeout(tmo_v[0]));

  mem_sort_checker #(.DATA_W(32), .N(4), .BASE_WORD(32), .ADDR_W(10),
                     .SIGNED(1), .DESCEND(1), .TIMEOUT(25840)) u_s (
    .clk(clk), .reset(reset), .start(start_v[1]),
    .mem_addr(maddr_v[1]), .mem_rdata(rdata_v[1]),
    .exp_addr(eaddr_v[1]), .exp_data(edata_v[1]),
    .busy(busy_v[1]), .done(done_v[1]),
    .err_unsorted(eu_v[1]), .err_exp(ee_v[1]),
    .pass(pass_v[1]), .timeout(tmo_v[1]));

  mem_sort_checker #(.DATA_W(32), .N(4), .BASE_WORD(32), .ADDR_W(10),
                     .SIGNED(0), .DESCEND(0), .TIMEOUT(10)) u_t (
    .clk(clk), .reset(reset), .start(start_v[2]),
    .mem_addr(maddr_v[2]), .mem_rdata(rdata_v[2]),
    .exp_addr(eaddr_v[2]), .exp_data(edata_v[2]),
    .busy(busy_v[2]), .done(done_v[2]),
    .err_unsorted(eu_v[2]), .err_exp(ee_v[2]),
    .pass(pass_v[2]), .timeout(tmo_v[2]));

  typedef struct {
    int                 k;
    logic [3:0][DW-1:0] m;
    logic [3:0][DW-1:0] e;
    int                 wu;
    int                 we;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic logic [3:0][DW-1:0] pk(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] c, input logic [DW-1:0] d);
    logic [3:0][DW-1:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  task automatic load(input int k, input logic [3:0][DW-1:0] m, input logic [3:0][DW-1:0] e);
    for (int i = 0; i < NW; i++) begin
      mem_m[k][32+i] = m[i];
      exp_m[k][i]    = e[i];
    end
  endtask

  // Reference: count mismatching words and adjacent pairs violating the order.
  task automatic model(input int k, output int wu, output int we);
    longint a, b;
    bit desc;
    desc = (k != 2);
    wu = 0;
    we = 0;
    for (int i = 0; i < NW; i++)
      if (mem_m[k][32+i] != exp_m[k][i]) we++;
    for (int i = 1; i < NW; i++) begin
      if (k == 1) begin
        a = $signed(mem_m[k][31+i]);
        b = $signed(mem_m[k][32+i]);
      end else begin
        a = mem_m[k][31+i];
        b = mem_m[k][32+i];
      end
      if (desc ? (a < b) : (a > b)) wu++;
    end
  endtask

  // Pulses start at the current negedge; optionally re-pulses start at busy cycle `poke`.
  task automatic do_scan(input int k, input string nm, input int wu, input int we, input int poke);
    bit ok;
    ok = 1'b1;
    start_v[k] = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= NW; c++) begin
      if (!(busy_v[k] === 1'b1 && done_v[k] === 1'b0)) ok = 1'b0;
      if (c == 1) check({nm, " cleared"}, {eu_v[k], ee_v[k]}, 0);
      start_v[k] = (c == poke);
      @(negedge clk);
    end
    start_v[k] = 1'b0;
    check({nm, " busy_window"}, ok, 1);
    check({nm, " busy_end"}, busy_v[k], 0);
    check({nm, " done"}, done_v[k], 1);
    check({nm, " err_unsorted"}, eu_v[k], wu);
    check({nm, " err_exp"}, ee_v[k], we);
    check({nm, " pass"}, pass_v[k], (wu == 0 && we == 0));
  endtask

  // Address bus must stay in the scanned window while busy and read 0 otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        if (busy_v[k] === 1'b1)
          check($sformatf("addr_scan%0d", k),
                (maddr_v[k] >= 32 && maddr_v[k] <= 35 && int'(eaddr_v[k]) == int'(maddr_v[k]) - 32), 1);
        else
          check($sformatf("addr_idle%0d", k), {maddr_v[k], eaddr_v[k]}, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wu, we, base, v;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      for (int a = 0; a < 1024; a++) begin
        mem_m[k][a] = 32'hDEAD_0000 + a;
        exp_m[k][a] = 32'hBEEF_0000 + a;
      end
    end

    tbl[0] = '{0, pk(9, 7, 7, 1), pk(9, 7, 7, 1), 0, 0};
    tbl[1] = '{0, pk(1, 2, 3, 4), pk(4, 3, 2, 1), 3, 4};
    tbl[2] = '{0, pk(5, 0, 32'hFFFF_FFFF, 32'h8000_0000), pk(5, 0, 32'hFFFF_FFFF, 32'h8000_0000), 1, 0};
    tbl[3] = '{1, pk(5, 0, 32'hFFFF_FFFF, 32'h8000_0000), pk(5, 0, 32'hFFFF_FFFF, 32'h8000_0000), 0, 0};
    tbl[4] = '{0, pk(7, 7, 7, 7), pk(7, 7, 8, 7), 0, 1};
    tbl[5] = '{2, pk(0, 0, 5, 3), pk(0, 0, 5, 3), 1, 0};
    tbl[6] = '{1, pk(32'hFFFF_FFFF, 0, 32'h7FFF_FFFF, 32'h8000_0000),
                  pk(32'hFFFF_FFFF, 0, 32'h7FFF_FFFF, 32'h8000_0000), 2, 0};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst busy%0d", k), busy_v[k], 0);
      check($sformatf("rst done%0d", k), done_v[k], 0);
      check($sformatf("rst counts%0d", k), {eu_v[k], ee_v[k]}, 0);
      check($sformatf("rst timeout%0d", k), tmo_v[k], 0);
    end
    reset = 1'b1;

    // Watchdog instance: start 12 cycles after reset release.
    repeat (5) @(negedge clk);
    check("tmo early", tmo_v[2], 0);
    repeat (7) @(negedge clk);
    load(2, pk(1, 2, 3, 4), pk(1, 2, 3, 4));
    do_scan(2, "tmo_scan", 0, 0, 0);
    check("tmo after done", tmo_v[2], 1);
    @(negedge clk);
    do_scan(2, "tmo_rescan", 0, 0, 0);
    check("tmo after rescan", tmo_v[2], 1);

    for (int i = 0; i < 7; i++) begin
      load(tbl[i].k, tbl[i].m, tbl[i].e);
      do_scan(tbl[i].k, $sformatf("vec%0d", i), tbl[i].wu, tbl[i].we, 0);
      @(negedge clk);
    end
    check("no tmo u_u", tmo_v[0], 0);
    check("no tmo u_s", tmo_v[1], 0);

    // Start during SCAN is ignored; start in DONE rescans with fresh counters.
    load(0, pk(1, 2, 3, 4), pk(4, 3, 2, 1));
    do_scan(0, "ignore_mid", 3, 4, 2);
    load(0, pk(9, 7, 7, 1), pk(9, 7, 7, 1));
    repeat (3) @(negedge clk);
    check("hold done", done_v[0], 1);
    check("hold counts", {eu_v[0], ee_v[0]}, {3'd3, 3'd4});
    do_scan(0, "restart_done", 0, 0, 0);

    // Reset on the second SCAN cycle aborts the scan.
    @(negedge clk);
    load(0, pk(1, 2, 3, 4), pk(4, 3, 2, 1));
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    check("pre-abort err_exp", ee_v[0], 1);
    reset = 1'b0;
    #1;
    check("abort busy", busy_v[0], 0);
    check("abort done", done_v[0], 0);
    check("abort counts", {eu_v[0], ee_v[0]}, 0);
    check("abort addr", maddr_v[0], 0);
    check("abort tmo cleared", tmo_v[2], 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("post-abort done", done_v[0], 0);
    check("post-abort busy", busy_v[0], 0);
    load(0, pk(9, 7, 7, 1), pk(9, 7, 7, 1));
    do_scan(0, "after_abort", 0, 0, 0);

    // Randomized scans against the reference model.
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < 3; k++) begin
        base = $urandom_range(0, 200) - 100;
        for (int i = 0; i < NW; i++) begin
          case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = base;
            2: v = (k == 2) ? base + $urandom_range(0, 40) : base - $urandom_range(0, 40);
            default: v = (i > 0) ? int'(mem_m[k][31+i]) : base;
          endcase
          base = v;
          mem_m[k][32+i] = v;
          exp_m[k][i]    = v;
        end
        if ($urandom_range(0, 1) == 1) exp_m[k][$urandom_range(0, 3)] ^= 32'h0000_0100;
        model(k, wu, we);
        do_scan(k, $sformatf("rnd%0d_%0d", it, k), wu, we, 0);
        @(negedge clk);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_sort_checker.md
MEM_SORT_CHECKER -- requirements
Module: mem_sort_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 32: memory word width.
REQ-002 SHALL have parameter N, default 96: number of words checked, N>=2.
REQ-003 SHALL have parameter BASE_WORD, default 32: word index of first checked word.
REQ-004 SHALL have parameter ADDR_W, default 10: word-address width of the memory and expected ports.
REQ-005 SHALL have parameter SIGNED, default 0: 1 selects two's-complement ordering, 0 unsigned.
REQ-006 SHALL have parameter DESCEND, default 1: 1 requires non-increasing order, 0 non-decreasing.
REQ-007 SHALL have parameter TIMEOUT, default 25840: cycle budget from reset release to start.
REQ-008 SHALL have port clk in 1: single clock, rising edge.
REQ-009 SHALL have port reset in 1: asynchronous, active-low reset.
REQ-010 SHALL have port start in 1: one-cycle request to begin a scan (driven when CPU PC reaches end address).
REQ-011 SHALL have port mem_addr out ADDR_W: word address into data memory.
REQ-012 SHALL have port mem_rdata in DATA_W: combinational read data for mem_addr, same cycle.
REQ-013 SHALL have port exp_addr out ADDR_W: index into expected-value store, 0..N-1.
REQ-014 SHALL have port exp_data in DATA_W: combinational expected word for exp_addr.
REQ-015 SHALL have port busy out 1: scan in progress.
REQ-016 SHALL have port done out 1: scan complete, results valid.
REQ-017 SHALL have port err_unsorted out CW=$clog2(N+1): count of out-of-order adjacent pairs.
REQ-018 SHALL have port err_exp out CW: count of words differing from expected.
REQ-019 SHALL have port pass out 1: done and both error counts zero.
REQ-020 SHALL have port timeout out 1: sticky, cycle budget exceeded.

Function
REQ-021 SHALL implement FSM states IDLE, SCAN, DONE; IDLE->SCAN on start, SCAN->DONE after index N-1, DONE->SCAN on start.
REQ-022 SHALL, on entering SCAN, clear both error counters and index to 0 in the same edge.
REQ-023 SHALL drive mem_addr = BASE_WORD+index and exp_addr = index, truncated to ADDR_W, during SCAN; 0 otherwise.
REQ-024 SHALL each SCAN cycle increment err_exp when mem_rdata != exp_data.
REQ-025 SHALL each SCAN cycle with index>0 compare prev (registered previous word) against mem_rdata; DESCEND=1 error when prev<mem_rdata, DESCEND=0 error when prev>mem_rdata; signedness per SIGNED.
REQ-026 SHALL check exactly N-1 pairs; no read beyond BASE_WORD+N-1.
REQ-027 SHALL saturate both counters at N; no wrap.
REQ-028 SHALL assert busy exactly N cycles, done first on the cycle after the last SCAN cycle (latency N+1 cycles from the start edge), and hold done and results until the next start.
REQ-029 SHALL ignore start while busy.
REQ-030 SHALL count cycles from reset release with a saturating counter, stop counting on first start, and set timeout when count exceeds TIMEOUT before start.
REQ-031 SHALL keep timeout set until reset; a later start does not clear it.
REQ-032 SHALL compute pass combinationally as done & (err_unsorted==0) & (err_exp==0).

Reset
REQ-033 SHALL, on reset low, asynchronously force state IDLE, index 0, prev 0, counters 0, busy 0, done 0, timeout 0, cycle count 0.
REQ-034 SHALL abort any scan on reset mid-operation; after release, no done until a new start.
REQ-035 SHALL leave mem_addr and exp_addr at 0 during reset.

Structure
REQ-036 SHALL place FSM state encoding and the shared compare function (signed/unsigned, ascending/descending) in package mips_tb_pkg.
REQ-037 SHALL instantiate one sub-module order_cmp (two DATA_W operands, SIGNED/DESCEND parameters, out_of_order output).
REQ-038 SHALL be synthesizable; no delays, file I/O or X-checks inside.

Verification (N=4, BASE_WORD=32, DATA_W=32 unless stated)
REQ-039 SHALL cover: mem[32..35]={9,7,7,1}, exp identical, start -> busy 4 cycles, done at start+5, err_unsorted=0, err_exp=0, pass=1.
REQ-040 SHALL cover: mem={1,2,3,4}, exp={4,3,2,1} -> err_unsorted=3, err_exp=4, pass=0.
REQ-041 SHALL cover: SIGNED=1, mem={5,0,0xFFFFFFFF,0x80000000} -> err_unsorted=0; SIGNED=0 same data -> err_unsorted=1.
REQ-042 SHALL cover: reset low on second SCAN cycle -> busy=0, done=0, counters 0; restart yields REQ-039 result.
REQ-043 SHALL cover: TIMEOUT=10, start at cycle 12 after reset release -> timeout=1, still 1 after done.
REQ-044 SHALL cover: start pulsed during SCAN and again in DONE -> first ignored, second clears counters and rescans with N-cycle busy.
